// File: rtl/tpm_opstate_ctrl_if.sv
// Command/response bus between the TPM command dispatcher (master) and the
// operational-state controller (slave).
interface tpm_opstate_ctrl_if;
  // A command transfers on a clock edge where cmd_valid and cmd_ready are both
  // high; the master holds cmd_* stable while cmd_valid waits for cmd_ready.
  // rsp_valid is a single-cycle pulse with no back-pressure, and rsp_rc holds
  // its value until the next pulse.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_cc;
  logic [32:0] cmd_param;
  logic [31:0] auth_hierarchy;
  logic [7:0]  locality;
  logic        rsp_valid;
  logic [31:0] rsp_rc;

  modport master (
    output cmd_valid, cmd_cc, cmd_param, auth_hierarchy, locality,
    input  cmd_ready, rsp_valid, rsp_rc
  );

  modport slave (
    input  cmd_valid, cmd_cc, cmd_param, auth_hierarchy, locality,
    output cmd_ready, rsp_valid, rsp_rc
  );
endinterface

// File: rtl/tpm_opstate_ctrl.sv
// TPM lifecycle FSM and hierarchy-enable owner; resolves management commands
// locally and forwards everything else to the execution engine.
module tpm_opstate_ctrl #(
  parameter int unsigned NUM_TESTS     = 40,
  parameter int unsigned TEST_W        = 16,
  parameter int unsigned ST_TIMEOUT    = 1024,
  parameter logic [7:0]  PLAT_LOCALITY = 8'h01
) (
  input  logic              clock,
  input  logic              reset_n,
  tpm_opstate_ctrl_if.slave cmd,
  input  logic [15:0]       orderly_in,
  input  logic              nv_ph_enable_nv,
  input  logic              nv_sh_enable,
  input  logic              nv_eh_enable,
  input  logic              init_done,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic [31:0]       exec_rc,
  input  logic              test_done,
  input  logic [TEST_W-1:0] tests_run,
  input  logic [TEST_W-1:0] tests_passed,
  input  logic [TEST_W-1:0] untested,
  output logic [2:0]        op_state,
  output logic [2:0]        startup_type,
  output logic              ph_enable,
  output logic              ph_enable_nv,
  output logic              sh_enable,
  output logic              eh_enable,
  output logic [15:0]       shutdown_save
);

  typedef enum logic [2:0] {
    S_POWER_OFF   = 3'd0,
    S_INIT        = 3'd1,
    S_STARTUP     = 3'd2,
    S_OPERATIONAL = 3'd3,
    S_SELF_TEST   = 3'd4,
    S_FAILURE     = 3'd5,
    S_SHUTDOWN    = 3'd6
  } state_t;

  localparam logic [31:0] CC_HIER_CTRL     = 32'h0000_0121;
  localparam logic [31:0] CC_INC_SELF_TEST = 32'h0000_0142;
  localparam logic [31:0] CC_SELF_TEST     = 32'h0000_0143;
  localparam logic [31:0] CC_STARTUP       = 32'h0000_0144;
  localparam logic [31:0] CC_SHUTDOWN      = 32'h0000_0145;
  localparam logic [31:0] CC_GET_CAP       = 32'h0000_017A;
  localparam logic [31:0] CC_GET_TEST_RES  = 32'h0000_017C;

  localparam logic [31:0] RC_SUCCESS    = 32'h0000_0000;
  localparam logic [31:0] RC_VALUE      = 32'h0000_0084;
  localparam logic [31:0] RC_INITIALIZE = 32'h0000_0100;
  localparam logic [31:0] RC_FAILURE    = 32'h0000_0101;
  localparam logic [31:0] RC_AUTH_TYPE  = 32'h0000_0124;
  localparam logic [31:0] RC_LOCALITY   = 32'h0000_0907;
  localparam logic [31:0] RC_TESTING    = 32'h0000_090A;

  localparam logic [31:0] RH_OWNER       = 32'h4000_0001;
  localparam logic [31:0] RH_ENDORSEMENT = 32'h4000_000B;
  localparam logic [31:0] RH_PLATFORM    = 32'h4000_000C;
  localparam logic [31:0] RH_PLATFORM_NV = 32'h4000_000D;

  localparam logic [2:0] SU_RESET   = 3'd1;
  localparam logic [2:0] SU_RESTART = 3'd2;
  localparam logic [2:0] SU_RESUME  = 3'd3;

  localparam int unsigned WD_W = $clog2(ST_TIMEOUT);

  state_t            state;
  logic              fwd_wait;
  logic              st_full;
  logic [WD_W-1:0]   wd_cnt;
  logic              accept;
  logic [15:0]       su;
  logic [31:0]       hc_target;
  logic              yes_no;
  logic              st_complete;

  assign op_state    = state;
  assign su          = cmd.cmd_param[15:0];
  assign hc_target   = cmd.cmd_param[32:1];
  assign yes_no      = cmd.cmd_param[0];
  assign st_complete = st_full ? (tests_passed == TEST_W'(NUM_TESTS)) : (untested == '0);

  assign cmd.cmd_ready = (state == S_INIT || state == S_OPERATIONAL || state == S_FAILURE)
                         && !fwd_wait && !cmd.rsp_valid;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_POWER_OFF;
      startup_type  <= 3'd0;
      ph_enable     <= 1'b0;
      ph_enable_nv  <= 1'b0;
      sh_enable     <= 1'b0;
      eh_enable     <= 1'b0;
      shutdown_save <= 16'd0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rc    <= 32'd0;
      exec_start    <= 1'b0;
      fwd_wait      <= 1'b0;
      st_full       <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      cmd.rsp_valid <= 1'b0;
      exec_start    <= 1'b0;

      // The engine's done is only trusted once the start pulse has dropped.
      if (fwd_wait && !exec_start && exec_done) begin
        fwd_wait      <= 1'b0;
        cmd.rsp_valid <= 1'b1;
        cmd.rsp_rc    <= exec_rc;
      end

      case (state)
        S_POWER_OFF: state <= S_INIT;

        S_INIT: begin
          if (accept) begin
            if (cmd.cmd_cc != CC_STARTUP) begin
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_rc    <= RC_INITIALIZE;
            end else if (su > 16'd1 || (su == 16'd1 && orderly_in != 16'd1)) begin
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_rc    <= RC_VALUE;
            end else begin
              state     <= S_STARTUP;
              ph_enable <= 1'b1;
              if (orderly_in == 16'd1 && su == 16'd1) begin
                startup_type <= SU_RESUME;
                ph_enable_nv <= nv_ph_enable_nv;
                sh_enable    <= nv_sh_enable;
                eh_enable    <= nv_eh_enable;
              end else begin
                startup_type <= (orderly_in == 16'd1) ? SU_RESTART : SU_RESET;
                ph_enable_nv <= 1'b1;
                sh_enable    <= 1'b1;
                eh_enable    <= 1'b1;
              end
            end
          end
        end

        S_STARTUP: begin
          if (init_done) begin
            state         <= S_OPERATIONAL;
            startup_type  <= 3'd0;
            cmd.rsp_valid <= 1'b1;
            cmd.rsp_rc    <= RC_SUCCESS;
          end
        end

        S_OPERATIONAL: begin
          if (accept) begin
            if (cmd.cmd_cc == CC_SELF_TEST || cmd.cmd_cc == CC_INC_SELF_TEST) begin
              st_full    <= yes_no;
              exec_start <= 1'b1;
              wd_cnt     <= '0;
              state      <= S_SELF_TEST;
            end else if (cmd.cmd_cc == CC_SHUTDOWN) begin
              cmd.rsp_valid <= 1'b1;
              if (su > 16'd1) begin
                cmd.rsp_rc <= RC_VALUE;
              end else begin
                cmd.rsp_rc    <= RC_SUCCESS;
                shutdown_save <= su;
                state         <= S_SHUTDOWN;
              end
            end else if (cmd.cmd_cc == CC_HIER_CTRL) begin
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_rc    <= RC_AUTH_TYPE;
              if (cmd.locality != PLAT_LOCALITY) begin
                cmd.rsp_rc <= RC_LOCALITY;
              end else if (cmd.auth_hierarchy == RH_PLATFORM) begin
                cmd.rsp_rc <= RC_SUCCESS;
                if (hc_target == RH_ENDORSEMENT)            eh_enable    <= yes_no;
                else if (hc_target == RH_OWNER)             sh_enable    <= yes_no;
                else if (hc_target == RH_PLATFORM_NV)       ph_enable_nv <= yes_no;
                else if (hc_target == RH_PLATFORM && !yes_no) ph_enable  <= 1'b0;
                else                                        cmd.rsp_rc   <= RC_VALUE;
              end else if (cmd.auth_hierarchy == RH_OWNER) begin
                if (hc_target == RH_OWNER && !yes_no) begin
                  sh_enable  <= 1'b0;
                  cmd.rsp_rc <= RC_SUCCESS;
                end
              end else if (cmd.auth_hierarchy == RH_ENDORSEMENT) begin
                if (hc_target == RH_ENDORSEMENT && !yes_no) begin
                  eh_enable  <= 1'b0;
                  cmd.rsp_rc <= RC_SUCCESS;
                end
              end
            end else begin
              exec_start <= 1'b1;
              fwd_wait   <= 1'b1;
            end
          end
        end

        S_SELF_TEST: begin
          // A test_done landing on the timeout cycle still takes priority.
          if (test_done) begin
            cmd.rsp_valid <= 1'b1;
            if (tests_passed != tests_run) begin
              state      <= S_FAILURE;
              cmd.rsp_rc <= RC_FAILURE;
            end else begin
              state      <= S_OPERATIONAL;
              cmd.rsp_rc <= st_complete ? exec_rc : RC_TESTING;
            end
          end else if (wd_cnt == WD_W'(ST_TIMEOUT - 1)) begin
            state         <= S_FAILURE;
            cmd.rsp_valid <= 1'b1;
            cmd.rsp_rc    <= RC_FAILURE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        S_FAILURE: begin
          if (accept) begin
            if (cmd.cmd_cc == CC_GET_TEST_RES || cmd.cmd_cc == CC_GET_CAP) begin
              exec_start <= 1'b1;
              fwd_wait   <= 1'b1;
            end else begin
              cmd.rsp_valid <= 1'b1;
              cmd.rsp_rc    <= RC_FAILURE;
            end
          end
        end

        S_SHUTDOWN: state <= S_INIT;

        default: state <= S_FAILURE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_opstate_ctrl.sv
// Self-checking bench for tpm_opstate_ctrl: response scoreboard, a table of
// HierarchyControl vectors and hand-written lifecycle sequences.
module tb_tpm_opstate_ctrl;
  localparam int TEST_W = 16;

  localparam logic [31:0] CC_HC        = 32'h0000_0121;
  localparam logic [31:0] CC_INC_ST    = 32'h0000_0142;
  localparam logic [31:0] CC_ST        = 32'h0000_0143;
  localparam logic [31:0] CC_STARTUP   = 32'h0000_0144;
  localparam logic [31:0] CC_SHUTDOWN  = 32'h0000_0145;
  localparam logic [31:0] CC_GET_CAP   = 32'h0000_017A;
  localparam logic [31:0] CC_GET_RAND  = 32'h0000_017B;
  localparam logic [31:0] CC_GET_TR    = 32'h0000_017C;

  localparam logic [31:0] RC_SUCCESS = 32'h000, RC_VALUE = 32'h084, RC_INIT = 32'h100;
  localparam logic [31:0] RC_FAILURE = 32'h101, RC_AUTH = 32'h124, RC_LOC = 32'h907;
  localparam logic [31:0] RC_TESTING = 32'h90A;

  localparam logic [31:0] RH_OWN = 32'h4000_0001, RH_END = 32'h4000_000B;
  localparam logic [31:0] RH_PLAT = 32'h4000_000C, RH_PNV = 32'h4000_000D;
  localparam logic [31:0] RH_BAD = 32'h4000_0007;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tpm_opstate_ctrl_if bus();

  logic [15:0]       orderly_in;
  logic              nv_ph_enable_nv, nv_sh_enable, nv_eh_enable;
  logic              init_done, exec_start, exec_done, test_done;
  logic [31:0]       exec_rc;
  logic [TEST_W-1:0] tests_run, tests_passed, untested;
  logic [2:0]        op_state, startup_type;
  logic              ph_enable, ph_enable_nv, sh_enable, eh_enable;
  logic [15:0]       shutdown_save;

  tpm_opstate_ctrl #(.ST_TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .cmd(bus),
    .orderly_in(orderly_in), .nv_ph_enable_nv(nv_ph_enable_nv),
    .nv_sh_enable(nv_sh_enable), .nv_eh_enable(nv_eh_enable),
    .init_done(init_done), .exec_start(exec_start), .exec_done(exec_done),
    .exec_rc(exec_rc), .test_done(test_done), .tests_run(tests_run),
    .tests_passed(tests_passed), .untested(untested), .op_state(op_state),
    .startup_type(startup_type), .ph_enable(ph_enable), .ph_enable_nv(ph_enable_nv),
    .sh_enable(sh_enable), .eh_enable(eh_enable), .shutdown_save(shutdown_save)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [31:0] auth;
    logic [31:0] target;
    logic        yn;
    logic [7:0]  loc;
    logic [31:0] rc;
    logic [3:0]  en;   // {ph, ph_nv, sh, eh} after the command
  } hc_vec_t;
  hc_vec_t hc_tab[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    logic [31:0] e;
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rc 0x%0h expected no response", bus.rsp_rc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rc", bus.rsp_rc, e);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [31:0] cc, input logic [32:0] param,
                      input logic [31:0] auth, input logic [31:0] exp);
    int n = 0;
    exp_q.push_back(exp);
    bus.cmd_valid = 1'b1;
    bus.cmd_cc = cc;
    bus.cmd_param = param;
    bus.auth_hierarchy = auth;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_ready_timeout: cc 0x%0h not accepted within 50 cycles", cc);
    end
    @(negedge clock);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_rsp_timeout: %0d responses missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_op_state"}, op_state, 0);
    check({tag, "_startup_type"}, startup_type, 0);
    check({tag, "_enables"}, {ph_enable, ph_enable_nv, sh_enable, eh_enable}, 0);
    check({tag, "_shutdown_save"}, shutdown_save, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_rc"}, bus.rsp_rc, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    check({tag, "_exec_start"}, exec_start, 0);
  endtask

  task automatic startup(input logic [15:0] su, input logic [15:0] orderly,
                         input logic [2:0] exp_type, input logic [3:0] exp_en);
    orderly_in = orderly;
    send(CC_STARTUP, {17'd0, su}, 32'd0, RC_SUCCESS);
    check("su_op_state", op_state, 2);
    check("su_type", startup_type, exp_type);
    check("su_enables", {ph_enable, ph_enable_nv, sh_enable, eh_enable}, exp_en);
    check("su_cmd_ready", bus.cmd_ready, 0);
    cycles(5);
    check("su_waiting", op_state, 2);
    init_done = 1'b1;
    @(negedge clock);
    init_done = 1'b0;
    wait_idle("startup");
    check("su_done_state", op_state, 3);
    check("su_done_type", startup_type, 0);
  endtask

  // Forwarded command; a done raised during the start pulse must be ignored.
  task automatic fwd(input logic [31:0] cc, input logic [31:0] rc, input int delay);
    send(cc, 33'd0, 32'd0, rc);
    check("fwd_exec_start", exec_start, 1);
    exec_done = 1'b1;
    exec_rc = 32'h0000_0BAD;
    @(negedge clock);
    exec_done = 1'b0;
    check("fwd_start_pulse", exec_start, 0);
    check("fwd_early_rsp", bus.rsp_valid, 0);
    cycles(delay);
    exec_rc = rc;
    exec_done = 1'b1;
    @(negedge clock);
    exec_done = 1'b0;
    check("fwd_rsp_latency", bus.rsp_valid, 1);
    wait_idle("fwd");
  endtask

  task automatic self_test(input logic [31:0] cc, input logic full, input int run,
                           input int passed, input int unt, input logic [31:0] eng_rc,
                           input int delay, input logic [31:0] exp, input logic [2:0] exp_state);
    tests_run = TEST_W'(run);
    tests_passed = TEST_W'(passed);
    untested = TEST_W'(unt);
    exec_rc = eng_rc;
    send(cc, {32'd0, full}, 32'd0, exp);
    check("st_state", op_state, 4);
    check("st_exec_start", exec_start, 1);
    cycles(delay);
    test_done = 1'b1;
    @(negedge clock);
    test_done = 1'b0;
    wait_idle("self_test");
    check("st_end_state", op_state, exp_state);
  endtask

  initial begin
    hc_tab[0]  = '{RH_PLAT, RH_OWN,  1'b0, 8'h01, RC_SUCCESS, 4'b1101};
    hc_tab[1]  = '{RH_PLAT, RH_OWN,  1'b0, 8'h00, RC_LOC,     4'b1101};
    hc_tab[2]  = '{RH_PLAT, RH_OWN,  1'b1, 8'h01, RC_SUCCESS, 4'b1111};
    hc_tab[3]  = '{RH_PLAT, RH_END,  1'b0, 8'h01, RC_SUCCESS, 4'b1110};
    hc_tab[4]  = '{RH_PLAT, RH_PNV,  1'b0, 8'h01, RC_SUCCESS, 4'b1010};
    hc_tab[5]  = '{RH_PLAT, RH_PNV,  1'b1, 8'h01, RC_SUCCESS, 4'b1110};
    hc_tab[6]  = '{RH_PLAT, RH_PLAT, 1'b1, 8'h01, RC_VALUE,   4'b1110};
    hc_tab[7]  = '{RH_PLAT, RH_BAD,  1'b0, 8'h01, RC_VALUE,   4'b1110};
    hc_tab[8]  = '{RH_OWN,  RH_OWN,  1'b1, 8'h01, RC_AUTH,    4'b1110};
    hc_tab[9]  = '{RH_OWN,  RH_OWN,  1'b0, 8'h01, RC_SUCCESS, 4'b1100};
    hc_tab[10] = '{RH_OWN,  RH_END,  1'b0, 8'h01, RC_AUTH,    4'b1100};
    hc_tab[11] = '{RH_END,  RH_END,  1'b1, 8'h01, RC_AUTH,    4'b1100};
    hc_tab[12] = '{RH_PLAT, RH_END,  1'b1, 8'h01, RC_SUCCESS, 4'b1101};
    hc_tab[13] = '{RH_END,  RH_END,  1'b0, 8'h01, RC_SUCCESS, 4'b1100};
    hc_tab[14] = '{RH_BAD,  RH_OWN,  1'b0, 8'h01, RC_AUTH,    4'b1100};
    hc_tab[15] = '{RH_PLAT, RH_PLAT, 1'b0, 8'h01, RC_SUCCESS, 4'b0100};
    hc_tab[16] = '{RH_PLAT, RH_END,  1'b1, 8'h02, RC_LOC,     4'b0100};

    bus.cmd_valid = 1'b0;
    bus.cmd_cc = '0;
    bus.cmd_param = '0;
    bus.auth_hierarchy = '0;
    bus.locality = 8'h01;
    orderly_in = 16'd0;
    nv_ph_enable_nv = 1'b0;
    nv_sh_enable = 1'b0;
    nv_eh_enable = 1'b0;
    init_done = 1'b0;
    exec_done = 1'b0;
    exec_rc = '0;
    test_done = 1'b0;
    tests_run = '0;
    tests_passed = '0;
    untested = '0;

    // Reset and power-on
    cycles(3);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clock);
    check("init_after_reset", op_state, 1);

    // INIT rejects everything but a valid Startup
    send(CC_GET_CAP, 33'd0, 32'd0, RC_INIT);
    wait_idle("init_getcap");
    check("init_stays", op_state, 1);
    send(CC_STARTUP, 33'd2, 32'd0, RC_VALUE);
    wait_idle("startup_su2");
    send(CC_STARTUP, 33'd1, 32'd0, RC_VALUE);
    wait_idle("startup_state_not_orderly");
    check("init_after_bad_startup", op_state, 1);

    startup(16'd0, 16'd0, 3'd1, 4'b1111);

    // HierarchyControl vector table
    for (int i = 0; i < 17; i++) begin
      bus.locality = hc_tab[i].loc;
      send(CC_HC, {hc_tab[i].target, hc_tab[i].yn}, hc_tab[i].auth, hc_tab[i].rc);
      check($sformatf("hc%0d_rsp_valid", i), bus.rsp_valid, 1);
      check($sformatf("hc%0d_enables", i), {ph_enable, ph_enable_nv, sh_enable, eh_enable},
            hc_tab[i].en);
      wait_idle("hc");
    end
    bus.locality = 8'h01;

    fwd(CC_GET_RAND, 32'h0000_0921, 3);

    // Shutdown / re-startup paths
    send(CC_SHUTDOWN, 33'd2, 32'd0, RC_VALUE);
    wait_idle("shutdown_bad");
    check("shutdown_bad_state", op_state, 3);
    send(CC_SHUTDOWN, 33'd0, 32'd0, RC_SUCCESS);
    check("shutdown0_state", op_state, 6);
    check("shutdown0_save", shutdown_save, 0);
    @(negedge clock);
    check("shutdown0_to_init", op_state, 1);
    wait_idle("shutdown0");
    startup(16'd0, 16'd1, 3'd2, 4'b1111);

    send(CC_SHUTDOWN, 33'd1, 32'd0, RC_SUCCESS);
    check("shutdown1_state", op_state, 6);
    check("shutdown1_save", shutdown_save, 1);
    @(negedge clock);
    check("shutdown1_to_init", op_state, 1);
    wait_idle("shutdown1");
    startup(16'd1, 16'd1, 3'd3, 4'b1000);

    // Self-test outcomes
    self_test(CC_ST,     1'b1, 40, 40, 7, 32'h0000_0000, 2, 32'h0000_0000, 3'd3);
    self_test(CC_INC_ST, 1'b0, 10, 10, 3, 32'h0000_0042, 2, RC_TESTING,    3'd3);
    self_test(CC_ST,     1'b1, 39, 39, 0, 32'h0000_0042, 2, RC_TESTING,    3'd3);
    self_test(CC_INC_ST, 1'b0, 5,  5,  0, 32'h0000_0042, 1, 32'h0000_0042, 3'd3);
    self_test(CC_ST,     1'b1, 40, 40, 0, 32'h0000_0077, 7, 32'h0000_0077, 3'd3);

    // Watchdog expiry with no test_done
    send(CC_ST, 33'd1, 32'd0, RC_FAILURE);
    check("wd_enter", op_state, 4);
    cycles(7);
    check("wd_before_timeout", op_state, 4);
    check("wd_no_rsp_yet", bus.rsp_valid, 0);
    cycles(1);
    check("wd_failure", op_state, 5);
    check("wd_rsp_valid", bus.rsp_valid, 1);
    wait_idle("watchdog");

    // FAILURE behaviour
    send(CC_HC, {RH_OWN, 1'b0}, RH_PLAT, RC_FAILURE);
    wait_idle("fail_hc");
    check("fail_sticky", op_state, 5);
    fwd(CC_GET_TR, 32'h0000_0055, 2);
    check("fail_after_fwd", op_state, 5);

    // Reset in the middle of a forwarded command
    send(CC_GET_CAP, 33'd0, 32'd0, 32'd0);
    check("midexec_start", exec_start, 1);
    cycles(2);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midexec");
    check("midexec_no_rsp", exp_q.size(), 1);
    exp_q.delete();
    exec_done = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reinit_state", op_state, 1);
    cycles(2);
    exec_done = 1'b0;
    cycles(2);

    // Second failure route: mismatched test counts
    startup(16'd0, 16'd0, 3'd1, 4'b1111);
    self_test(CC_ST, 1'b1, 40, 39, 0, 32'h0000_0000, 3, RC_FAILURE, 3'd5);
    send(CC_HC, {RH_OWN, 1'b0}, RH_PLAT, RC_FAILURE);
    wait_idle("fail2_hc");
    send(CC_STARTUP, 33'd0, 32'd0, RC_FAILURE);
    wait_idle("fail2_startup");
    check("fail2_enables_kept", {ph_enable, ph_enable_nv, sh_enable, eh_enable}, 4'b1111);
    cycles(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
